// File: rtl/pmem_pkg.sv
// Purpose: shared types and helpers for the pmem responder slice.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package pmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int WORD_BYTES = 8;

  // Expand an 8-bit byte-enable into a 64-bit bit mask.
  function automatic logic [63:0] expand_mask(input logic [WORD_BYTES-1:0] m);
    logic [63:0] e;
    e = '0;
    for (int i = 0; i < WORD_BYTES; i++) begin
      e[8*i +: 8] = {8{m[i]}};
    end
    return e;
  endfunction

endpackage

// File: rtl/pmem_ram.sv
// Purpose: DEPTH_WORDS x 64-bit RAM, byte-masked synchronous write, synchronous read.
// Latency: read data registered one edge after re; write lands on the same edge as we.
// Backpressure: none; the caller pulses we/re for exactly one edge per access.
// Ports: clk; we/re strobes; addr word index; wdata/wmask write data and byte
// enables; rdata registered read data (holds until the next re).
module pmem_ram
  import pmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int IW          = $clog2(DEPTH_WORDS)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic                  re,
  input  logic [IW-1:0]         addr,
  input  logic [63:0]           wdata,
  input  logic [WORD_BYTES-1:0] wmask,
  output logic [63:0]           rdata
);

  logic [63:0] mem [DEPTH_WORDS];
  logic [63:0] bit_mask;

  assign bit_mask = expand_mask(wmask);

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= (mem[addr] & ~bit_mask) | (wdata & bit_mask);
    end
    if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/pmem_responder.sv
// Purpose: single-outstanding data-memory responder with range check and internal RAM.
// Latency: response valid LATENCY+1 cycles after the accept edge; req_ready back one cycle after resp handshake.
// Backpressure: resp_valid/rdata/err held stable while resp_ready=0; req_ready low until the response is taken.
// Ports: clk/rst (sync, active-high); req_* valid/ready request channel with
// write flag, byte address, write data and byte mask; resp_* valid/ready response
// channel carrying read data (0 for writes and errors) and the out-of-range flag.
module pmem_responder
  import pmem_pkg::*;
#(
  parameter logic [63:0] ADDR_BASE   = 64'h0000_0000_8000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [63:0]           req_addr,
  input  logic [63:0]           req_wdata,
  input  logic [WORD_BYTES-1:0] req_wmask,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [63:0]           resp_rdata,
  output logic                  resp_err
);

  localparam int          IW       = $clog2(DEPTH_WORDS);
  localparam logic [63:0] ADDR_END = ADDR_BASE + 64'(DEPTH_WORDS) * 64'(WORD_BYTES);
  localparam bit          ZERO_LAT = (LATENCY == 0);
  localparam logic [3:0]  CNT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  state_t state_q, state_d;
  logic [3:0] cnt_q;

  // Transaction fields captured at accept.
  logic                  wr_q;
  logic                  err_q;
  logic [IW-1:0]         idx_q;
  logic [63:0]           wdata_q;
  logic [WORD_BYTES-1:0] wmask_q;

  // Response registers; rd_zero_q forces rdata to 0 for writes, errors and after reset.
  logic resp_err_q;
  logic rd_zero_q;

  logic                  accept;
  logic                  commit;
  logic                  in_err;
  logic [63:0]           in_off;
  logic [IW-1:0]         in_idx;
  logic                  c_wr;
  logic                  c_err;
  logic [IW-1:0]         c_idx;
  logic [63:0]           c_wdata;
  logic [WORD_BYTES-1:0] c_wmask;
  logic                  ram_we;
  logic                  ram_re;
  logic [63:0]           ram_rdata;

  // Range check on the raw incoming address (unsigned, no wrap).
  assign in_err = (req_addr < ADDR_BASE) | (req_addr >= ADDR_END);
  assign in_off = req_addr - ADDR_BASE;
  assign in_idx = IW'(in_off >> 3);

  assign accept = req_valid & req_ready;

  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    commit     = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = ~rst;
        if (req_valid && !rst) begin
          if (ZERO_LAT) begin
            state_d = RESP;
            commit  = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          commit  = 1'b1;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // With zero latency the commit edge is the accept edge, so the RAM must see
  // the live request; otherwise it sees the fields latched at accept.
  assign c_wr    = (state_q == IDLE) ? req_write : wr_q;
  assign c_err   = (state_q == IDLE) ? in_err    : err_q;
  assign c_idx   = (state_q == IDLE) ? in_idx    : idx_q;
  assign c_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
  assign c_wmask = (state_q == IDLE) ? req_wmask : wmask_q;

  // rst gating drops a transaction whose commit edge coincides with reset.
  assign ram_we = commit & c_wr  & ~c_err & ~rst;
  assign ram_re = commit & ~c_wr & ~c_err & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      resp_err_q <= 1'b0;
      rd_zero_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cnt_q <= CNT_LOAD;
      end else if (state_q == WAIT && cnt_q != 4'd0) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (commit) begin
        resp_err_q <= c_err;
        rd_zero_q  <= c_wr | c_err;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      wr_q    <= req_write;
      err_q   <= in_err;
      idx_q   <= in_idx;
      wdata_q <= req_wdata;
      wmask_q <= req_wmask;
    end
  end

  pmem_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IW          (IW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (c_idx),
    .wdata (c_wdata),
    .wmask (c_wmask),
    .rdata (ram_rdata)
  );

  assign resp_rdata = rd_zero_q ? 64'd0 : ram_rdata;
  assign resp_err   = resp_err_q;

endmodule

// File: doc/pmem_responder.md
# pmem_responder

Memory-side responder for the core's data-memory port. It accepts one read or write request at a time over a valid/ready handshake and holds an internal byte-maskable 64-bit RAM. It returns a response after a programmable latency. It is the RTL replacement for the behavioural pmem read/write model, sitting between the core's load/store path and the simulated physical memory.

## Interface
Parameters:
- ADDR_BASE, 64'h0000_0000_8000_0000, byte address of word 0
- DEPTH_WORDS, 1024, number of 64-bit words (power of two, ≥2)
- LATENCY, 2, wait cycles between accept and response (0..15)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  responder can accept request
- req_write  in  1  1 = write, 0 = read
- req_addr  in  64  byte address; bits [2:0] ignored
- req_wdata  in  64  write data
- req_wmask  in  8  byte enables; bit i covers wdata[8i+7:8i]
- resp_valid  out  1  response present
- resp_ready  in  1  initiator accepts response
- resp_rdata  out  64  read data; 0 for writes and errors
- resp_err  out  1  address out of range

## Operation
- States: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready, latch write, word index ((addr−ADDR_BASE)>>3), wdata, wmask and range flag.
  - Next state is WAIT if LATENCY>0, else RESP.
- Range check: err = (addr < ADDR_BASE) | (addr ≥ ADDR_BASE + DEPTH_WORDS*8). Compute in 64-bit unsigned arithmetic; there is no wrap.
- WAIT:
  - Counter loads LATENCY−1 on accept and decrements each cycle.
  - At 0, go to RESP.
  - req_ready=0.
- Transition into RESP (same edge):
  - Write: bytes with wmask=1 are committed; other bytes are unchanged. wmask=0 commits nothing but still responds. No commit when err.
  - Read: resp_rdata is registered from the RAM word, or 0 when err.
  - resp_err is registered.
- RESP:
  - resp_valid=1.
  - resp_rdata and resp_err are held stable until resp_valid&resp_ready, then the next state is IDLE.
  - req_ready=0.
  - There is no same-cycle accept of a new request in RESP.
- Only one outstanding transaction; requests never overlap.
- Reset:
  - State goes to IDLE, counter to 0, resp_valid=0, resp_rdata=0, resp_err=0.
  - req_ready=0 during any cycle rst is high.
  - RAM contents are not reset.
- Reset mid-operation: the transaction is dropped with no response. A write is not committed unless its commit edge was already passed.

## Timing
- Request accepted at edge of cycle 0: resp_valid is first high in cycle LATENCY+1.
- With resp_ready tied high:
  - resp handshake occurs in cycle LATENCY+1.
  - req_ready returns in cycle LATENCY+2.
  - Throughput is one transaction per LATENCY+2 cycles.
- Backpressure: resp_valid stays high indefinitely while resp_ready=0; outputs are stable.
- req_ready is a function of state and rst only. It does not depend combinationally on req_valid.
- A write followed by a read of the same word returns the new data; commit precedes the next accept.

## Structure
- Shared package pmem_pkg:
  - state enum {IDLE, WAIT, RESP}.
  - localparam WORD_BYTES=8.
  - function for the 64-bit byte-mask expansion (8→64).
- Sub-module pmem_ram: DEPTH_WORDS×64 array with a synchronous byte-masked write port and a synchronous read port, index width $clog2(DEPTH_WORDS).
- The FSM, latency counter, range check and response registers live in pmem_responder.

## Test plan
- Reset, then write addr 0x8000_0000, wdata 0x1122334455667788, wmask 0xFF, LATENCY=2 → resp_valid in cycle 3, err=0, rdata=0. A read of the same address returns 0x1122334455667788.
- Partial write: wmask 0x0F, wdata 0xAAAAAAAA_BBBBBBBB over the prior word → read returns 0x11223344_BBBBBBBB.
- Out of range: read addr 0x7FFF_FFF8 and addr 0x8000_2000 (DEPTH 1024) → err=1, rdata=0. A write to 0x8000_2000 leaves all words unchanged.
- Backpressure: hold resp_ready=0 for 5 cycles → resp_valid and rdata stable and req_ready=0 throughout. Release → IDLE next cycle.
- LATENCY=0 build: accept in cycle 0 → resp_valid in cycle 1. Back-to-back accepts occur every 2 cycles.
- Reset asserted in WAIT of a write to 0x8000_0010 → no response, resp_valid=0, and a later read of 0x8000_0010 returns the pre-write value.
